vga_timing_gen: RTL

Parametrised VGA raster timing generator with a pixel-alignment pipeline. It produces raster coordinates for the pixel store and colour decoder. It delays hsync/vsync/blank_b to match those blocks' read latency and outputs blanked RGB to the video DAC. It generalises the fixed 640x480 controller: resolution, porches, sync polarity and pipeline depth are parameters, and it adds a pixel-clock enable plus frame/line start strobes.

---
 rtl/vga_timing_gen_if.sv | 35 +++
 rtl/vga_timing_gen.sv | 126 ++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster-side and video-side signal bundle of vga_timing_gen.
// The generator uses the master view; the pixel store / DAC side uses the slave view.
interface vga_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int CW = 4
);
  logic          en;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          active;
  logic          line_start;
  logic          frame_start;
  logic [CW-1:0] r_in;
  logic [CW-1:0] g_in;
  logic [CW-1:0] b_in;
  logic          hsync;
  logic          vsync;
  logic          blank_b;
  logic [CW-1:0] r_out;
  logic [CW-1:0] g_out;
  logic [CW-1:0] b_out;

  modport master (
    input  en, r_in, g_in, b_in,
    output x, y, active, line_start, frame_start,
    output hsync, vsync, blank_b, r_out, g_out, b_out
  );

  modport slave (
    output en, r_in, g_in, b_in,
    input  x, y, active, line_start, frame_start,
    input  hsync, vsync, blank_b, r_out, g_out, b_out
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster counter with a sync/blank delay line that lines the
// syncs up with colour returned PIPE_DLY pixel-enables after its coordinate.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIPE_DLY  = 2,
  parameter int CW        = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW           = $clog2(H_TOTAL);
  localparam int YW           = $clog2(V_TOTAL);
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Delay-line bit layout: [2] hsync, [1] vsync, [0] blank_b.
  localparam logic [2:0] PIPE_RST = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      PIPE_DLY < 0) begin : g_bad_params
    $error("vga_timing_gen: every H_*/V_* term must be non-zero and PIPE_DLY >= 0");
  end

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          hs_raw;
  logic          vs_raw;
  logic          active_raw;
  logic [2:0]    pipe_in;
  logic [2:0]    pipe_q [PIPE_DLY+1];
  logic [2:0]    pipe_d [PIPE_DLY+1];
  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] g_q, g_d;
  logic [CW-1:0] b_q, b_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (vif.en) begin
      if (x_q == XW'(H_TOTAL - 1)) begin
        x_d = '0;
        y_d = (y_q == YW'(V_TOTAL - 1)) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_comb begin
    hs_raw     = (x_q >= XW'(H_SYNC_START) && x_q < XW'(H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
    vs_raw     = (y_q >= YW'(V_SYNC_START) && y_q < YW'(V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
    active_raw = (x_q < XW'(H_ACTIVE)) && (y_q < YW'(V_ACTIVE));
    pipe_in    = {hs_raw, vs_raw, active_raw};
  end

  always_comb begin
    pipe_d[0] = vif.en ? pipe_in : pipe_q[0];
    for (int i = 1; i <= PIPE_DLY; i++) begin
      pipe_d[i] = vif.en ? pipe_q[i-1] : pipe_q[i];
    end
  end

  // Gate with the blank bit entering the last stage, so colour and its syncs
  // reach the ports on the same edge.
  always_comb begin
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    if (vif.en) begin
      r_d = pipe_d[PIPE_DLY][0] ? vif.r_in : '0;
      g_d = pipe_d[PIPE_DLY][0] ? vif.g_in : '0;
      b_d = pipe_d[PIPE_DLY][0] ? vif.b_in : '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
      for (int i = 0; i <= PIPE_DLY; i++) begin
        pipe_q[i] <= PIPE_RST;
      end
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      for (int i = 0; i <= PIPE_DLY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.active      = active_raw;
  assign vif.line_start  = vif.en && (x_q == '0);
  assign vif.frame_start = vif.en && (x_q == '0) && (y_q == '0);
  assign vif.hsync       = pipe_q[PIPE_DLY][2];
  assign vif.vsync       = pipe_q[PIPE_DLY][1];
  assign vif.blank_b     = pipe_q[PIPE_DLY][0];
  assign vif.r_out       = r_q;
  assign vif.g_out       = g_q;
  assign vif.b_out       = b_q;

endmodule
